// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download bridge: the queued word
// format, the request FSM states and the byte-lane encodings.
package rom_dl_pkg;

  localparam int DL_AW = 22;

  localparam logic [1:0] DS_LO = 2'b01;
  localparam logic [1:0] DS_HI = 2'b10;
  localparam logic [1:0] DS_W  = 2'b11;

  typedef struct packed {
    logic [DL_AW-1:0] a;
    logic [1:0]       ds;
    logic [15:0]      d;
  } dl_word_t;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    WAIT,
    DONE
  } dl_state_t;

endpackage

// File: rtl/rom_dl_fifo.sv
// Small synchronous FIFO of packed download words. A push while full is
// accepted only when a pop frees a slot in the same cycle; otherwise it drops.
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   push,
  input  dl_word_t               wdata,
  input  logic                   pop,
  output dl_word_t               rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  dl_word_t      mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage carries no reset; the pointers and count define what is valid
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rom_dl_bridge.sv
// Packs the data_io byte stream into 16-bit sdram writes, queues them and
// drives the port1 toggle handshake; flags completion once all writes land.
//
// state | meaning
// SYNC  | first cycle after reset, align port_req to port_ack
// IDLE  | no request outstanding, issue the next queued word
// WAIT  | request outstanding, address/data held until ack matches
// DONE  | download ended and fully written, rom_loaded high
module rom_dl_bridge
  import rom_dl_pkg::*;
#(
  parameter int AW    = DL_AW,
  parameter int DEPTH = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          port_req,
  input  logic          port_ack,
  output logic [AW-1:0] port_a,
  output logic [1:0]    port_ds,
  output logic [15:0]   port_d,
  output logic          port_we,
  output logic          busy,
  output logic          rom_loaded,
  output logic          overflow
);

  dl_state_t state, state_n;

  logic          wr_q, dl_q, edge_q, odd_q, ended;
  logic [AW-1:0] a_q;
  logic [7:0]    data_q;
  logic          wr_edge, dl_rise, dl_fall;

  logic          pend_v, pend_v_n;
  logic [AW-1:0] pend_a, pend_a_n;
  logic [7:0]    pend_lo, pend_lo_n;
  logic          skid_v, skid_v_n;
  dl_word_t      skid_w, skid_w_n;
  dl_word_t      pend_word, hi_word;

  logic          push, pop, issue, set_loaded, drained;
  dl_word_t      push_w, head;
  logic          fifo_empty, fifo_drop, unused_full;
  logic [$clog2(DEPTH):0] fifo_count;
  logic          unused_addr;

  assign unused_addr = ^ioctl_addr[24:AW+1];

  assign wr_edge = ioctl_download & ioctl_wr & ~wr_q;
  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;

  // Byte packing one cycle after the write edge; a lone odd byte that follows
  // an unrelated pending byte needs two pushes, the second goes via the skid.
  always_comb begin
    push      = 1'b0;
    push_w    = '0;
    pend_v_n  = pend_v;
    pend_a_n  = pend_a;
    pend_lo_n = pend_lo;
    skid_v_n  = 1'b0;
    skid_w_n  = skid_w;
    pend_word = '{a: pend_a, ds: DS_LO, d: {pend_lo, pend_lo}};
    hi_word   = '{a: a_q, ds: DS_HI, d: {data_q, data_q}};
    if (skid_v) begin
      push   = 1'b1;
      push_w = skid_w;
    end else if (edge_q) begin
      if (!odd_q) begin
        push      = pend_v;
        push_w    = pend_word;
        pend_v_n  = 1'b1;
        pend_a_n  = a_q;
        pend_lo_n = data_q;
      end else if (pend_v && pend_a == a_q) begin
        push     = 1'b1;
        push_w   = '{a: a_q, ds: DS_W, d: {data_q, pend_lo}};
        pend_v_n = 1'b0;
      end else if (pend_v) begin
        push     = 1'b1;
        push_w   = pend_word;
        skid_v_n = 1'b1;
        skid_w_n = hi_word;
        pend_v_n = 1'b0;
      end else begin
        push   = 1'b1;
        push_w = hi_word;
      end
    end else if (!dl_q && pend_v) begin
      push     = 1'b1;
      push_w   = pend_word;
      pend_v_n = 1'b0;
    end
  end

  rom_dl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (push_w),
    .pop     (pop),
    .rdata   (head),
    .full    (unused_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .drop    (fifo_drop)
  );

  assign drained = ended & ~ioctl_download & ~pend_v & ~skid_v & ~edge_q & fifo_empty;

  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    issue      = 1'b0;
    set_loaded = 1'b0;
    unique case (state)
      SYNC: state_n = IDLE;
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          issue   = 1'b1;
          state_n = WAIT;
        end else if (drained) begin
          set_loaded = 1'b1;
          state_n    = DONE;
        end
      end
      WAIT: begin
        // finishing straight from the last ack keeps rom_loaded one cycle behind it
        if (port_ack == port_req) begin
          if (drained) begin
            set_loaded = 1'b1;
            state_n    = DONE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DONE: if (dl_rise) state_n = IDLE;
      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SYNC;
      wr_q       <= 1'b0;
      dl_q       <= 1'b0;
      edge_q     <= 1'b0;
      odd_q      <= 1'b0;
      a_q        <= '0;
      data_q     <= '0;
      ended      <= 1'b0;
      pend_v     <= 1'b0;
      pend_a     <= '0;
      pend_lo    <= '0;
      skid_v     <= 1'b0;
      skid_w     <= '0;
      port_req   <= 1'b0;
      port_a     <= '0;
      port_ds    <= '0;
      port_d     <= '0;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state   <= state_n;
      wr_q    <= ioctl_wr;
      dl_q    <= ioctl_download;
      edge_q  <= wr_edge;
      if (wr_edge) begin
        a_q    <= ioctl_addr[AW:1];
        odd_q  <= ioctl_addr[0];
        data_q <= ioctl_dout;
      end
      pend_v  <= pend_v_n;
      pend_a  <= pend_a_n;
      pend_lo <= pend_lo_n;
      skid_v  <= skid_v_n;
      skid_w  <= skid_w_n;

      if (state == SYNC) begin
        port_req <= port_ack;
      end else if (issue) begin
        port_req <= ~port_req;
        port_a   <= head.a;
        port_ds  <= head.ds;
        port_d   <= head.d;
      end

      if (dl_fall)      ended <= 1'b1;
      else if (dl_rise) ended <= 1'b0;

      if (dl_rise) begin
        rom_loaded <= 1'b0;
        overflow   <= 1'b0;
      end
      if (set_loaded) rom_loaded <= 1'b1;
      if (fifo_drop)  overflow   <= 1'b1;
    end
  end

  assign busy    = pend_v | skid_v | edge_q | (fifo_count != '0) | (state == WAIT);
  assign port_we = ioctl_download | busy;

endmodule

// File: tb/tb_rom_dl_bridge.sv
// Bench for rom_dl_bridge: directed download scenarios plus a random byte
// stream, with expected sdram writes derived from the byte-packing rules.
module tb_rom_dl_bridge;

  typedef struct packed {
    logic [21:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } w_t;

  localparam int M_HOLD = 0;
  localparam int M_AUTO = 1;
  localparam int M_ONE  = 2;
  localparam int M_NOW  = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        port_req;
  logic        port_ack = 1'b1;
  logic [21:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic        port_we, busy, rom_loaded, overflow;

  int   ack_mode = M_ONE;
  bit   mon_en = 1'b0;
  logic last_req = 1'b0;
  w_t   got_q[$];
  w_t   exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  bit          m_pv = 1'b0;
  logic [21:0] m_pa = '0;
  logic [7:0]  m_plo = '0;

  rom_dl_bridge #(.AW(22), .DEPTH(4)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .port_req       (port_req),
    .port_ack       (port_ack),
    .port_a         (port_a),
    .port_ds        (port_ds),
    .port_d         (port_d),
    .port_we        (port_we),
    .busy           (busy),
    .rom_loaded     (rom_loaded),
    .overflow       (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // sdram side: acknowledge per mode and log every request toggle
  always @(negedge clk_sys) begin
    case (ack_mode)
      M_AUTO:  if (port_ack !== port_req && $urandom_range(0, 2) == 0) port_ack = port_req;
      M_ONE:   port_ack = 1'b1;
      M_NOW:   port_ack = port_req;
      default: ;
    endcase
    if (!mon_en) begin
      last_req = port_req;
    end else if (port_req !== last_req) begin
      got_q.push_back('{a: port_a, ds: port_ds, d: port_d});
      last_req = port_req;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic model_byte(input logic [24:0] ad, input logic [7:0] dt);
    logic [21:0] a;
    a = ad[22:1];
    if (!ad[0]) begin
      if (m_pv) exp_q.push_back('{a: m_pa, ds: 2'b01, d: {m_plo, m_plo}});
      m_pv = 1'b1;
      m_pa = a;
      m_plo = dt;
    end else if (m_pv && m_pa == a) begin
      exp_q.push_back('{a: a, ds: 2'b11, d: {dt, m_plo}});
      m_pv = 1'b0;
    end else begin
      if (m_pv) exp_q.push_back('{a: m_pa, ds: 2'b01, d: {m_plo, m_plo}});
      exp_q.push_back('{a: a, ds: 2'b10, d: {dt, dt}});
      m_pv = 1'b0;
    end
  endtask

  task automatic model_end();
    if (m_pv) exp_q.push_back('{a: m_pa, ds: 2'b01, d: {m_plo, m_plo}});
    m_pv = 1'b0;
  endtask

  task automatic wr_byte(input logic [24:0] ad, input logic [7:0] dt);
    ioctl_addr = ad;
    ioctl_dout = dt;
    ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    tick(2);
    model_byte(ad, dt);
  endtask

  task automatic wait_reqs(input int n, input bit need_ack, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      ok = (got_q.size() >= n) && (!need_ack || port_ack === port_req);
    end
    chk({tag, "_wait"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_loaded(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      ok = (rom_loaded === 1'b1);
    end
    chk({tag, "_loaded"}, 64'(ok), 64'd1);
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [24:0] ad;

    // reset state, then SYNC copies port_ack=1 into port_req
    tick(3);
    chk("rst_req", 64'(port_req), 64'd0);
    chk("rst_a", 64'(port_a), 64'd0);
    chk("rst_ds", 64'(port_ds), 64'd0);
    chk("rst_d", 64'(port_d), 64'd0);
    chk("rst_we", 64'(port_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_loaded", 64'(rom_loaded), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    chk("sync_pre", 64'(port_req), 64'd0);
    tick(1);
    chk("sync_req", 64'(port_req), 64'd1);
    tick(3);
    chk("sync_noreq", 64'(port_req), 64'd1);
    chk("sync_busy", 64'(busy), 64'd0);
    ack_mode = M_HOLD;
    mon_en = 1'b1;

    // first word and its request latency
    ioctl_download = 1'b1;
    tick(1);
    wr_byte(25'h0, 8'h11);
    ioctl_addr = 25'h1;
    ioctl_dout = 8'h22;
    ioctl_wr = 1'b1;
    tick(1);
    chk("lat_n0", 64'(port_req), 64'd1);
    ioctl_wr = 1'b0;
    tick(1);
    chk("lat_n1", 64'(port_req), 64'd1);
    tick(1);
    chk("lat_n2", 64'(port_req), 64'd0);
    chk("lat_a", 64'(port_a), 64'd0);
    chk("lat_ds", 64'(port_ds), 64'd3);
    chk("lat_d", 64'(port_d), 64'h2211);
    model_byte(25'h1, 8'h22);
    ack_mode = M_AUTO;
    wait_reqs(exp_q.size(), 1'b1, 100, "lat");
    cmp_q("lat_q");

    // lone bytes, then a word above the address range
    wr_byte(25'h4, 8'hAA);
    wr_byte(25'h7, 8'hBB);
    wr_byte(25'h1800010, 8'h33);
    wr_byte(25'h1800011, 8'h44);
    wait_reqs(exp_q.size(), 1'b1, 200, "lone");
    cmp_q("lone_q");

    // overflow with ack stalled: 1 outstanding + 4 queued, 6th dropped
    ack_mode = M_HOLD;
    for (int w = 0; w < 6; w++) begin
      if (w == 5) chk("ovf_before", 64'(overflow), 64'd0);
      wr_byte(25'h200 + 25'(2 * w), 8'($urandom));
      wr_byte(25'h201 + 25'(2 * w), 8'($urandom));
    end
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_busy", 64'(busy), 64'd1);
    void'(exp_q.pop_back());
    ack_mode = M_AUTO;
    wait_reqs(exp_q.size(), 1'b1, 300, "ovf");
    ioctl_download = 1'b0;
    wait_loaded(200, "ovf");
    chk("ovf_we", 64'(port_we), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    cmp_q("ovf_q");

    // fresh download of 0x0F bytes, odd count leaves byte 0x0E to flush
    ioctl_download = 1'b1;
    tick(2);
    chk("rise_loaded", 64'(rom_loaded), 64'd0);
    chk("rise_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 15; i++) wr_byte(25'(i), 8'($urandom));
    wait_reqs(7, 1'b1, 300, "dl16");
    ack_mode = M_HOLD;
    ioctl_download = 1'b0;
    model_end();
    wait_reqs(8, 1'b0, 100, "flush");
    chk("flush_a", 64'(port_a), 64'd7);
    chk("flush_ds", 64'(port_ds), 64'd1);
    chk("flush_loaded0", 64'(rom_loaded), 64'd0);
    chk("flush_we1", 64'(port_we), 64'd1);
    ack_mode = M_NOW;
    tick(1);
    chk("flush_loaded1", 64'(rom_loaded), 64'd1);
    chk("flush_we0", 64'(port_we), 64'd0);
    ack_mode = M_AUTO;
    cmp_q("dl16_q");

    // reset while a request is outstanding
    ioctl_download = 1'b1;
    tick(1);
    ack_mode = M_HOLD;
    wr_byte(25'h20, 8'h5A);
    wr_byte(25'h21, 8'hA5);
    wait_reqs(1, 1'b0, 100, "mid");
    cmp_q("mid_q");
    ioctl_download = 1'b0;
    mon_en = 1'b0;
    ack_mode = M_ONE;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(port_req), 64'd0);
    chk("mid_rst_a", 64'(port_a), 64'd0);
    chk("mid_rst_ds", 64'(port_ds), 64'd0);
    chk("mid_rst_d", 64'(port_d), 64'd0);
    chk("mid_rst_we", 64'(port_we), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    m_pv = 1'b0;
    tick(2);
    reset_n = 1'b1;
    chk("mid_sync_pre", 64'(port_req), 64'd0);
    tick(1);
    chk("mid_sync", 64'(port_req), 64'd1);
    ack_mode = M_AUTO;
    tick(1);
    mon_en = 1'b1;

    // random byte stream after the reset
    ioctl_download = 1'b1;
    tick(1);
    ad = 25'h41;
    for (int i = 0; i < 12; i++) begin
      wr_byte(ad, 8'($urandom));
      ad = ad + 25'($urandom_range(1, 3));
    end
    chk("rnd_loaded0", 64'(rom_loaded), 64'd0);
    ioctl_download = 1'b0;
    model_end();
    wait_reqs(exp_q.size(), 1'b1, 500, "rnd");
    wait_loaded(100, "rnd");
    chk("rnd_ovf", 64'(overflow), 64'd0);
    cmp_q("rnd_q");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
